// File: rtl/fir_mac_scheduler.sv
// ============================================================================
// Module      : fir_mac_scheduler
// Description : Sequencer for a symmetric band-pass FIR on EEG samples. It
//               folds the N-tap convolution onto one pre-add/multiply/
//               accumulate unit over HALF_N cycles, owns the sample ring and
//               the per-band coefficient banks, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fir_mac_scheduler #(
  parameter int N         = 64,
  parameter int HALF_N    = N / 2,
  parameter int DW        = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  parameter int NUM_BANDS = 4,
  parameter int BW        = $clog2(NUM_BANDS),
  parameter int KW        = $clog2(HALF_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_sample,
  input  logic [BW-1:0]    band_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             coef_wr_en,
  input  logic [BW-1:0]    coef_wr_band,
  input  logic [KW-1:0]    coef_wr_addr,
  input  logic [DW-1:0]    coef_wr_data,
  output logic             busy
);

  localparam int AW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W-1:0] c_sat_max =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]              r_state;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_newest;
  logic [KW-1:0]           r_k;
  logic [BW-1:0]           r_band;
  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0]        r_out_data;
  logic [DW-1:0]           r_buf  [N];
  logic [DW-1:0]           r_coef [NUM_BANDS][HALF_N];

  logic                    w_accept;
  logic                    w_coef_we;
  logic                    w_last;
  logic [AW-1:0]           w_idx_a;
  logic [AW-1:0]           w_idx_b;
  logic [DW-1:0]           w_tap_a;
  logic [DW-1:0]           w_tap_b;
  logic [DW-1:0]           w_coef;
  logic signed [DW:0]      w_pre;
  logic signed [2*DW:0]    w_coef_ext;
  logic signed [2*DW:0]    w_pre_ext;
  logic signed [2*DW:0]    w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_sat;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_coef_we = (r_state == S_IDLE) && coef_wr_en;
  assign w_last    = (r_k == KW'(HALF_N - 1));

  // Tap k pairs with tap N-1-k; (newest-(N-1-k)) mod N folds to newest+1+k.
  assign w_idx_a = r_newest - AW'(r_k);
  assign w_idx_b = r_newest + AW'(r_k) + AW'(1);
  assign w_tap_a = r_buf[w_idx_a];
  assign w_tap_b = r_buf[w_idx_b];
  assign w_coef  = r_coef[r_band][r_k];

  assign w_pre      = {w_tap_a[DW-1], w_tap_a} + {w_tap_b[DW-1], w_tap_b};
  assign w_coef_ext = {{(DW+1){w_coef[DW-1]}}, w_coef};
  assign w_pre_ext  = {{DW{w_pre[DW]}}, w_pre};
  assign w_prod     = w_coef_ext * w_pre_ext;
  assign w_sum      = r_acc + {{(ACC_W-2*DW-1){w_prod[2*DW]}}, w_prod};

  always_comb begin
    w_sat = w_sum[OUT_W-1:0];
    if (w_sum > c_sat_max) begin
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_sum < c_sat_min) begin
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_newest   <= '0;
      r_k        <= '0;
      r_band     <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_newest <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_band   <= band_sel;
            r_acc    <= '0;
            r_k      <= '0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + KW'(1);
          if (w_last) begin
            r_out_data <= w_sat;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= in_sample;
    end
  end

  // Banks are frozen outside IDLE so a running convolution sees one coefficient set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int t = 0; t < HALF_N; t++) begin
          r_coef[b][t] <= '0;
        end
      end
    end else if (w_coef_we) begin
      r_coef[coef_wr_band][coef_wr_addr] <= coef_wr_data;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
// ============================================================================
// Module      : tb_fir_mac_scheduler
// Description : Self-checking bench for fir_mac_scheduler against a
//               transaction-level model of the symmetric FIR.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_mac_scheduler;

  localparam longint c_smax = 64'sd2147483647;
  localparam longint c_smin = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = '0;
  logic [1:0]  band_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        coef_wr_en = 1'b0;
  logic [1:0]  coef_wr_band = '0;
  logic [4:0]  coef_wr_addr = '0;
  logic [15:0] coef_wr_data = '0;
  logic        busy;

  fir_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .band_sel(band_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_wr_en(coef_wr_en), .coef_wr_band(coef_wr_band), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  int     m_coef [4][32];
  int     hist [$];
  longint exp_q [$];
  longint got [$];
  bit     m_busy = 1'b0;
  int     m_age = 0;
  int     mode = 0;

  function automatic void chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Sample j positions back from the newest; anything never written reads as zero.
  function automatic longint xs(int j);
    if (j < hist.size()) return longint'(hist[hist.size()-1-j]);
    return 0;
  endfunction

  function automatic longint model_out(int b);
    longint s = 0;
    for (int k = 0; k < 32; k++) s += longint'(m_coef[b][k]) * (xs(k) + xs(63 - k));
    if (s > c_smax) s = c_smax;
    else if (s < c_smin) s = c_smin;
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst out_valid", longint'(out_valid), 0);
      chk("rst in_ready", longint'(in_ready), 1);
      chk("rst busy", longint'(busy), 0);
      chk("rst out_data", longint'(out_data), 0);
      for (int b = 0; b < 4; b++) for (int k = 0; k < 32; k++) m_coef[b][k] = 0;
      hist.delete();
      exp_q.delete();
      got.delete();
      m_busy = 1'b0;
      m_age = 0;
    end else begin
      if (m_busy) m_age++;
      chk("in_ready", longint'(in_ready), longint'(!m_busy));
      chk("busy", longint'(busy), longint'(m_busy));
      chk("out_valid", longint'(out_valid), longint'(m_busy && m_age >= 33));
      if (m_busy && m_age >= 33) begin
        if (exp_q.size() == 0) begin
          chk("out_data no expectation", 1, 0);
        end else begin
          chk("out_data", longint'($signed(out_data)), exp_q[0]);
          if (out_ready) begin
            got.push_back(longint'($signed(out_data)));
            void'(exp_q.pop_front());
            m_busy = 1'b0;
          end
        end
      end else if (!m_busy) begin
        if (coef_wr_en) m_coef[coef_wr_band][coef_wr_addr] = int'($signed(coef_wr_data));
        if (in_valid) begin
          hist.push_back(int'($signed(in_sample)));
          if (hist.size() > 64) void'(hist.pop_front());
          exp_q.push_back(model_out(int'(band_sel)));
          m_busy = 1'b1;
          m_age = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      tick();
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic wr_coef(input logic [1:0] b, input logic [4:0] a, input logic [15:0] d);
    coef_wr_en = 1'b1; coef_wr_band = b; coef_wr_addr = a; coef_wr_data = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic push(input logic [15:0] s, input logic [1:0] b, input bit we = 1'b0,
                      input logic [1:0] wb = 2'd0, input logic [4:0] wa = 5'd0,
                      input logic [15:0] wd = 16'd0);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_sample = s; band_sel = b;
    coef_wr_en = we; coef_wr_band = wb; coef_wr_addr = wa; coef_wr_data = wd;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    coef_wr_en = 1'b0;
    if (!acc) chk("push timeout", 0, 1);
  endtask

  task automatic wait_result(output longint v);
    int n = 0;
    while (got.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    if (got.size() == 0) begin
      chk("result timeout", 0, 1);
      v = 0;
    end else begin
      v = got.pop_front();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 400) begin
      tick();
      n++;
    end
    if (m_busy) chk("idle timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready", longint'(in_ready), 1);
    chk("async rst out_valid", longint'(out_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    longint v;
    longint v0;
    int     edges;
    bit     seen;
    logic [15:0] rs;

    repeat (3) tick();
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset busy", longint'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Single unit tap: the 100 appears when it is newest and again when it sits at offset 63.
    wr_coef(2'd0, 5'd0, 16'd1);
    for (int i = 1; i <= 65; i++) begin
      push((i == 1) ? 16'd100 : 16'd0, 2'd0);
      wait_result(v);
      chk($sformatf("impulse s%0d", i), v, (i == 1 || i == 64) ? 100 : 0);
    end

    push(16'd55, 2'd0);
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) seen = 1'b1;
    end
    chk("latency edges", longint'(edges), 32);
    wait_result(v);
    chk("latency value", v, 55);

    mode = 2;
    push(16'hFED4, 2'd0);
    for (int n = 0; n < 60 && !out_valid; n++) tick();
    v0 = longint'($signed(out_data));
    in_valid = 1'b1; in_sample = 16'd77; band_sel = 2'd0;
    repeat (10) tick();
    chk("bp out_data stable", longint'($signed(out_data)), v0);
    chk("bp out_valid held", longint'(out_valid), 1);
    chk("bp in_ready low", longint'(in_ready), 0);
    mode = 0;
    push(16'd77, 2'd0);
    wait_result(v);
    chk("bp first", v, -300);
    wait_result(v);
    chk("bp second", v, 77);

    for (int k = 0; k < 32; k++) wr_coef(2'd1, 5'(k), 16'h7FFF);
    for (int i = 0; i < 64; i++) begin
      push(16'h7FFF, 2'd1);
      wait_result(v);
    end
    chk("sat max", v, 2147483647);
    for (int i = 0; i < 64; i++) begin
      push(16'h8000, 2'd1);
      wait_result(v);
    end
    chk("sat min", v, -64'sd2147483648);

    do_reset();
    wr_coef(2'd2, 5'd0, 16'd2);
    wr_coef(2'd3, 5'd0, 16'd3);
    push(16'd10, 2'd2);
    wait_result(v);
    chk("band2", v, 20);
    push(16'd10, 2'd3);
    wr_coef(2'd3, 5'd0, 16'd5);
    wait_result(v);
    chk("band3", v, 30);
    push(16'd10, 2'd3);
    wait_result(v);
    chk("band3 locked", v, 30);

    push(16'd10, 2'd3);
    repeat (15) tick();
    do_reset();
    push(16'd7, 2'd0, 1'b1, 2'd0, 5'd0, 16'd1);
    wait_result(v);
    chk("post reset sample", v, 7);
    push(16'd10, 2'd3);
    wait_result(v);
    chk("post reset band3 cleared", v, 0);

    mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) wait_idle();
      if ($urandom_range(0, 1) == 1)
        wr_coef(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom));
      rs = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
      push(rs, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 400)));
    end
    wait_idle();
    mode = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
